// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - two-stage pipelined 16-bit shifter/rotator with valid/ready on both sides
// Stage 1 applies distances 1 and 2, stage 2 applies distances 4 and 8.

module shift_pipe_stage #(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       amt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] data_out
);

  // op: 00 ROL, 01 SLL, 10 ROR, 11 SRL; k is always a constant here
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       o,
                                                input int               k);
    logic [WIDTH-1:0] r;
    case (o)
      2'b00:   r = (d << k) | (d >> (WIDTH - k));
      2'b01:   r = d << k;
      2'b10:   r = (d >> k) | (d << (WIDTH - k));
      default: r = d >> k;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] mid;

  assign mid      = amt[0] ? shift_by(data_in, op, DIST) : data_in;
  assign data_out = amt[1] ? shift_by(mid, op, 2 * DIST) : mid;

endmodule

module shift_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_cnt;
  logic [1:0]       s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;

  logic             in_xfer;
  logic             adv2;
  logic [WIDTH-1:0] s1_next_data;
  logic [WIDTH-1:0] s2_next_data;

  shift_pipe_stage #(.WIDTH(WIDTH), .DIST(1)) u_stage1 (
    .data_in  (in_data),
    .amt      (in_cnt[1:0]),
    .op       (in_op),
    .data_out (s1_next_data)
  );

  shift_pipe_stage #(.WIDTH(WIDTH), .DIST(4)) u_stage2 (
    .data_in  (s1_data),
    .amt      (s1_cnt),
    .op       (s1_op),
    .data_out (s2_next_data)
  );

  // stage 2 can take stage 1 when it is empty or being drained this cycle
  assign adv2     = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || adv2;
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_cnt   <= '0;
      s1_op    <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_data  <= s1_next_data;
        s1_cnt   <= in_cnt[3:2];
        s1_op    <= in_op;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (adv2) begin
        s2_valid <= 1'b1;
        s2_data  <= s2_next_data;
      end else if (s2_valid && out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zero  = (s2_data == '0);

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Two-stage pipelined 16-bit shifter/rotator for the execute datapath.
- Wraps the per-distance mux stages (shift by 1/2/4/8) with pipeline registers and a valid/ready handshake on both sides.
- Sits between operand select (upstream) and the ALU result mux / writeback (downstream).
- Stage 1 applies distances 1 and 2; stage 2 applies distances 4 and 8.

Parameters:
WIDTH, 16, data width; must equal 2**CNT_W
CNT_W, 4, shift-amount width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents an operation
in_ready  output  1  block accepts an operation this cycle
in_data  input  WIDTH  operand
in_cnt  input  CNT_W  shift amount, 0..WIDTH-1
in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL
out_valid  output  1  result available
out_ready  input  1  downstream consumes the result this cycle
out_data  output  WIDTH  shifted/rotated result
out_zero  output  1  out_data == 0

Behaviour:
- Reset is asynchronous and active-low, on rst_n.
  - Clears s1_valid, s2_valid, and all data, cnt and op registers to 0.
  - out_valid=0, out_data=0, out_zero=1, in_ready=1 while reset is asserted and immediately after release.
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Stage 1 register (s1_*):
  - On input transfer, captures the partially shifted data (in_cnt[1:0] applied), plus in_cnt[3:2] and in_op.
  - Sets s1_valid.
- Stage 2 register (s2_*):
  - Captures the stage-1 data with s1_cnt[3:2] applied.
  - out_data = s2_data; out_valid = s2_valid.
- Advance rules:
  - adv2 = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || adv2. This is combinational; it depends on out_ready, not on in_valid.
  - If adv2 and no input transfer: s1_valid clears.
  - If s2_valid, out_ready and not adv2: s2_valid clears.
  - Simultaneous input transfer and adv2: stage 1 reloads and stays valid.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid.
  - Throughput 1 op/cycle when out_ready is held high.
  - Ordering is strictly preserved; no op is dropped or duplicated.
- Stall:
  - With out_ready=0, at most 2 ops are in flight.
  - in_ready drops once both stages are valid.
  - Held registers do not change while stalled.
- Arithmetic, each applied distance d:
  - SLL: zero-fill at LSBs.
  - SRL: zero-fill at MSBs.
  - ROL/ROR: bits wrap around.
  - Composition of the 1/2/4/8 stages equals a single shift by cnt.
  - cnt=0 passes data unchanged for every op.
  - cnt is taken mod WIDTH by construction; no out-of-range case exists.
- out_zero is derived combinationally from s2_data.
- Reset mid-operation: in-flight ops are discarded and no stale out_valid appears after release.
- Inputs are ignored when in_valid=0; X on in_data/in_cnt/in_op must not propagate into valid state.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, out_data=0x0000, out_zero=1, in_ready=1 immediately, without waiting for an edge.
- Basic latency, out_ready=1: SLL 0x1234 cnt 4 -> 0x2340 with out_valid exactly 2 edges after the transfer. SRL 0x8000 cnt 15 -> 0x0001. SLL 0xFFFF cnt 15 -> 0x8000, out_zero=0.
- Rotates: ROL 0x8001 cnt 1 -> 0x0003. ROR 0x0001 cnt 15 -> 0x0002. ROL 0xABCD cnt 8 -> 0xCDAB. Any op with cnt 0 on 0x5A5A -> 0x5A5A.
- Zero flag: SRL 0x0001 cnt 1 -> 0x0000, out_zero=1.
- Backpressure: hold out_ready=0 and offer ops A,B,C back-to-back.
  - A and B are accepted; in_ready=0 while C is held.
  - Raise out_ready -> results A,B,C appear on consecutive cycles, in order, with no duplicates.
- Reset mid-flight: 2 ops in pipeline, pulse rst_n low for a half cycle -> after release out_valid=0 and no result from either op ever appears.
- Random soak: 10k random ops with random in_valid/out_ready against a reference model -> all results match, in order.
